// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative RV32M mul/div unit.
package muldiv_pkg;

  // Operand/result width; only 32 is supported.
  localparam int unsigned XLEN  = 32;
  // Iteration counter width, wide enough to hold XLEN.
  localparam int unsigned CNT_W = 6;

  // funct3 encodings.
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign correction.
module muldiv_sign_fix #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring divide on magnitudes,
// with the sign applied when the result is registered on entry to DONE.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {rem, dividend/quot}
  logic [XLEN-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;     // final result must be negated
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_signed, b_signed, a_neg, b_neg, start_neg;
  logic                div_zero, div_ovf, fast;
  logic [XLEN-1:0]     a_mag, b_mag, fast_res;

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       rem_shift;
  logic                div_ge;
  logic [XLEN-1:0]     div_sub;
  logic [2*XLEN-1:0]   mul_nxt, div_nxt, step_nxt;
  logic [2*XLEN-1:0]   fin_val, fin_fix;
  logic [XLEN-1:0]     fin_res;
  logic                load;

  // Decode incoming request: operand signedness, result sign and the fast-path cases.
  always_comb begin
    a_signed  = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_signed  = op[2] ? ~op[0] : ~op[1];
    a_neg     = a_signed & a[XLEN-1];
    b_neg     = b_signed & b[XLEN-1];
    // Remainder takes the dividend sign; everything else takes the product/quotient sign.
    start_neg = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero  = op[2] & (b == '0);
    div_ovf   = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    fast      = div_zero | div_ovf;
    if (div_zero) begin
      fast_res = op[1] ? a : '1;
    end else begin
      fast_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  muldiv_sign_fix #(.W(XLEN)) u_a_mag (
    .val (a),
    .neg (a_neg),
    .res (a_mag)
  );

  muldiv_sign_fix #(.W(XLEN)) u_b_mag (
    .val (b),
    .neg (b_neg),
    .res (b_mag)
  );

  // One iteration of shift-add multiply and of restoring divide; op selects which is kept.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = (rem_shift >= {1'b0, opnd_q});
    div_sub   = rem_shift[XLEN-1:0] - opnd_q;
    if (div_ge) begin
      div_nxt = {div_sub, acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_nxt = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
    step_nxt = op_q[2] ? div_nxt : mul_nxt;
  end

  // Select the raw value to be sign-corrected from the final step.
  always_comb begin
    if (!op_q[2]) begin
      fin_val = step_nxt;
    end else begin
      fin_val = {{XLEN{1'b0}}, (op_q[1] ? step_nxt[2*XLEN-1:XLEN] : step_nxt[XLEN-1:0])};
    end
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_res_fix (
    .val (fin_val),
    .neg (neg_q),
    .res (fin_fix)
  );

  assign fin_res = (op_q[2] || (op_q[1:0] == 2'b00)) ? fin_fix[XLEN-1:0]
                                                      : fin_fix[2*XLEN-1:XLEN];

  // FSM next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        load = start & ~flush;
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d  = DONE;
            result_d = fin_res;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        load    = start & ~flush;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      op_d  = op;
      neg_d = start_neg;
      cnt_d = '0;
      if (fast) begin
        state_d  = DONE;
        result_d = fast_res;
        acc_d    = '0;
        opnd_d   = '0;
      end else begin
        state_d = CALC;
        if (op[2]) begin
          acc_d  = {{XLEN{1'b0}}, a_mag};
          opnd_d = b_mag;
        end else begin
          acc_d  = {{XLEN{1'b0}}, b_mag};
          opnd_d = a_mag;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests  = 0;
  int failed = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle, then scramble the operands.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
    op    = 3'($urandom_range(0, 7));
  endtask

  // Expect busy=1/done=0 for 32 cycles; optionally pulse start while busy at step inj.
  task automatic run_calc(input string tag, input int inj);
    int bad;
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (i == inj) begin
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd5;
        b     = 32'd0;
      end
      tick();
      start = 1'b0;
    end
    chk({tag, " busy"}, 32'(bad), 32'd0);
  endtask

  task automatic chk_done(input string tag, input logic [31:0] exp);
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " result"}, result, exp);
  endtask

  initial begin
    int cnt;
    rst   = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'b000;
    a     = 32'd0;
    b     = 32'd0;
    tick();
    tick();
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b1;
    tick();

    // Multiply.
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    run_calc("mul", 0);
    chk_done("mul", 32'hFFFF_FFEB);
    tick();
    chk("mul after done", {31'b0, done}, 32'd0);
    chk("mul hold", result, 32'hFFFF_FFEB);

    issue(OP_MULH, 32'h8000_0000, 32'h8000_0000);
    run_calc("mulh", 0);
    chk_done("mulh", 32'h4000_0000);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_calc("mulhu", 0);
    chk_done("mulhu", 32'hFFFF_FFFE);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_calc("mulhsu", 0);
    chk_done("mulhsu", 32'hFFFF_FFFF);
    tick();

    // Divide, back-to-back from DONE.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_calc("div", 0);
    chk_done("div", 32'hFFFF_FFFD);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2);
    run_calc("rem", 0);
    chk_done("rem", 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'd100, 32'd7);
    run_calc("divu", 0);
    chk_done("divu", 32'd14);
    issue(OP_REMU, 32'd100, 32'd7);
    run_calc("remu", 0);
    chk_done("remu", 32'd2);
    tick();

    // Fast paths.
    issue(OP_DIV, 32'd5, 32'd0);
    chk_done("div0", 32'hFFFF_FFFF);
    tick();
    chk("div0 after done", {31'b0, done}, 32'd0);
    issue(OP_REMU, 32'd5, 32'd0);
    chk_done("remu0", 32'd5);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    chk_done("rem ovf", 32'd0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk_done("div ovf", 32'h8000_0000);
    tick();

    // Flush mid-CALC.
    issue(OP_DIVU, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush done", {31'b0, done}, 32'd0);
    chk("flush result", result, 32'h8000_0000);
    cnt = 0;
    for (int i = 0; i < 35; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) cnt++;
      tick();
    end
    chk("flush quiet", 32'(cnt), 32'd0);

    // Start while busy is ignored.
    issue(OP_MUL, 32'd3, 32'd4);
    run_calc("mul34", 5);
    chk_done("mul34", 32'd12);
    tick();
    chk("mul34 after done", {31'b0, done}, 32'd0);
    chk("mul34 after busy", {31'b0, busy}, 32'd0);

    // Start and flush together: flush wins.
    op    = OP_MUL;
    a     = 32'd3;
    b     = 32'd4;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("start+flush busy", {31'b0, busy}, 32'd0);
    chk("start+flush done", {31'b0, done}, 32'd0);
    tick();
    chk("start+flush busy2", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-CALC.
    issue(OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF);
    for (int i = 0; i < 14; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst busy", {31'b0, busy}, 32'd0);
    chk("arst done", {31'b0, done}, 32'd0);
    chk("arst result", result, 32'd0);
    tick();
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) cnt++;
      tick();
    end
    chk("arst quiet", 32'(cnt), 32'd0);
    chk("arst result hold", result, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the register file read ports.
- Consumes the rs1/rs2 operand values after forwarding, runs a 32-step shift-add multiply or restoring divide, and returns one 32-bit result.
- Asserts busy so the hazard unit freezes IF/ID/EX while a long operation is in flight.

Parameters:
- XLEN, 32, operand/result width; the only supported value is 32.
- CNT_W, 6, iteration counter width, wide enough to hold XLEN.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; sampled only when busy=0.
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  32  rs1 operand value (dividend / multiplicand).
- b  input  32  rs2 operand value (divisor / multiplier).
- flush  input  1  abort in-flight operation (branch mispredict or trap).
- busy  output  1  high throughout CALC.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  32  registered result; holds its value until the next done.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, all internal operand/accumulator registers=0.
- States:
  - IDLE: start=1 and flush=0 → latch a, b, op; compute operand magnitudes and result sign; go to CALC with counter=0. Fast-path cases go straight to DONE.
  - CALC: one multiply or divide step per cycle; counter increments; when counter reaches 31 the step completes, then go to DONE.
  - DONE: done=1 and result is updated in this cycle. If start=1 → accept the new op (back-to-back); otherwise → IDLE.
- Output decodes: busy = (state==CALC); done = (state==DONE).
- Latency: start accepted at edge T → done high in cycle T+33 (32 CALC cycles, then DONE). Fast path: done in cycle T+1.
- Multiply:
  - Operate on magnitudes: |a| if op is MUL/MULH/MULHSU and a[31]=1; |b| if op is MUL/MULH and b[31]=1.
  - Accumulate a 64-bit product; negate it in DONE when the result sign is 1.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide:
  - Restoring algorithm on magnitudes, producing a 32-bit quotient and remainder.
  - Signed cases (DIV/REM): quotient sign = a[31]^b[31]; remainder sign = a[31].
  - The sign fix is applied in the DONE cycle.
- Fast path, no CALC cycles:
  - b=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - DIV with a=0x80000000 and b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- start while busy=1: ignored, with no effect on the in-flight operation.
- flush while in CALC or DONE: next state is IDLE, no done pulse, result keeps its old value.
- flush and start in the same cycle: flush wins and start is dropped.
- Reset asserted mid-CALC: immediate return to the reset values; no done pulse after release.
- a and b need only be stable in the start cycle; later changes to them have no effect.

Decomposition:
- muldiv_pkg holds:
  - XLEN;
  - op encoding localparams (OP_MUL … OP_REMU);
  - state typedef/localparams IDLE, CALC, DONE.
- One sub-module, muldiv_sign_fix: combinational conditional two's-complement negate of a 64-bit value, instantiated for both operand magnitude and result correction.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, start at T → busy cycles T+1..T+32; done in T+33 with result=0xFFFFFFEB; busy=0 during done.
- MULH a=b=0x80000000 → 0x40000000; MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU a=100, b=7 → 14; REMU a=100, b=7 → 2. Issue these back-to-back via start during done; each result arrives 33 cycles after its start.
- DIV a=5, b=0 → done in T+1 with result=0xFFFFFFFF; REMU a=5, b=0 → 5; DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 in T+1; REM with the same operands → 0.
- DIVU started at T, flush at T+10 → busy=0 from T+11, no done, result unchanged. Then start MUL 3×4 → 12 after 33 cycles. Also check: start with flush in the same cycle → no busy; start while busy → ignored.
- rst driven low at T+15 of a MUL → busy, done and result read 0 before the next clk edge. After release, no done appears within 40 cycles.
